// File: rtl/dcsk_pkg.sv
// Shared types and helpers for the DCSK transmit path.
package dcsk_pkg;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_REF,
        TX_DATA,
        TX_DONE
    } tx_state_t;

    localparam int SF_MIN = 2;
    localparam int SF_W   = 5;

    // Requested spread factors outside [SF_MIN, sf_max] saturate to the nearest legal slot length.
    function automatic logic [SF_W-1:0] sf_clamp(input logic [SF_W-1:0] sf, input int sf_max);
        int sf_i;
        sf_i = int'(sf);
        if (sf_i < SF_MIN) begin
            sf_i = SF_MIN;
        end else if (sf_i > sf_max) begin
            sf_i = sf_max;
        end
        return SF_W'(sf_i);
    endfunction

endpackage

// File: rtl/dcsk_slot_counter.sv
// Chip counter for one reference or data slot; wraps to zero after the terminal chip.
module dcsk_slot_counter #(
    parameter int CNT_W = 5
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             clear,
    input  logic             enable,
    input  logic [CNT_W-1:0] terminal,
    output logic [CNT_W-1:0] count,
    output logic             last
);

    assign last = (count == terminal);

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= last ? '0 : count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/dcsk_tx_sequencer.sv
// DCSK transmit sequencer: per data bit, one reference slot of fresh chaos chips
// followed by one data slot replaying the stored chips modulated by the bit.
module dcsk_tx_sequencer
    import dcsk_pkg::*;
#(
    parameter int WORD_W = 32,
    parameter int SF_MAX = 16,
    parameter int ADDR_W = $clog2(SF_MAX)
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Tx_Enable,
    input  logic              In_Valid,
    output logic              In_Ready,
    input  logic [WORD_W-1:0] In_Word,
    input  logic [4:0]        Spread_Factor,
    output logic              Chaos_Step,
    output logic [ADDR_W-1:0] Del_Reg_Addr,
    output logic              Del_Reg_Load,
    output logic              Del_Reg_Re,
    output logic              Data_Slot,
    output logic              Tx_Bit,
    output logic              Chip_Valid,
    output logic              Word_Done,
    output logic              Aborted
);

    localparam int CNT_W = ADDR_W + 1;
    localparam int BIT_W = $clog2(WORD_W);

    tx_state_t         state;
    tx_state_t         state_next;
    logic [CNT_W-1:0]  chip_cnt;
    logic [CNT_W-1:0]  sf_q;
    logic [CNT_W-1:0]  sf_term;
    logic [BIT_W-1:0]  bit_idx;
    logic [WORD_W-1:0] word_q;
    logic [SF_W-1:0]   sf_clamped;
    logic              chip_last;
    logic              bit_last;
    logic              busy;
    logic              abort;
    logic              accept;
    logic              aborted_q;

    assign busy       = (state == TX_REF) || (state == TX_DATA);
    assign abort      = busy & ~Tx_Enable;
    assign In_Ready   = ~Rst & Tx_Enable & ((state == TX_IDLE) || (state == TX_DONE));
    assign accept     = In_Valid & In_Ready;
    assign bit_last   = (bit_idx == BIT_W'(WORD_W - 1));
    assign sf_clamped = sf_clamp(Spread_Factor, SF_MAX);
    assign sf_term    = sf_q - CNT_W'(1);

    dcsk_slot_counter #(
        .CNT_W(CNT_W)
    ) u_slot_counter (
        .Clk      (Clk),
        .Rst      (Rst),
        .clear    (abort),
        .enable   (busy & Tx_Enable),
        .terminal (sf_term),
        .count    (chip_cnt),
        .last     (chip_last)
    );

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state <= TX_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Word and slot length are frozen at accept so mid-word input changes cannot disturb the slots.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            word_q <= '0;
            sf_q   <= '0;
        end else if (accept) begin
            word_q <= In_Word;
            sf_q   <= CNT_W'(sf_clamped);
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            bit_idx <= '0;
        end else if (abort) begin
            bit_idx <= '0;
        end else if ((state == TX_DATA) && chip_last) begin
            bit_idx <= bit_last ? '0 : bit_idx + BIT_W'(1);
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            aborted_q <= 1'b0;
        end else begin
            aborted_q <= abort;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            TX_IDLE: begin
                if (accept) state_next = TX_REF;
            end
            TX_REF: begin
                if (!Tx_Enable)     state_next = TX_IDLE;
                else if (chip_last) state_next = TX_DATA;
            end
            TX_DATA: begin
                if (!Tx_Enable)     state_next = TX_IDLE;
                else if (chip_last) state_next = bit_last ? TX_DONE : TX_REF;
            end
            TX_DONE: begin
                state_next = accept ? TX_REF : TX_IDLE;
            end
            default: state_next = TX_IDLE;
        endcase
    end

    always_comb begin
        Chaos_Step   = 1'b0;
        Del_Reg_Load = 1'b0;
        Del_Reg_Re   = 1'b0;
        Data_Slot    = 1'b0;
        Tx_Bit       = 1'b0;
        Chip_Valid   = 1'b0;
        Word_Done    = 1'b0;
        Del_Reg_Addr = '0;
        unique case (state)
            TX_REF: begin
                Chaos_Step   = 1'b1;
                Del_Reg_Load = 1'b1;
                Chip_Valid   = 1'b1;
                Del_Reg_Addr = ADDR_W'(chip_cnt);
            end
            TX_DATA: begin
                Del_Reg_Re   = 1'b1;
                Chip_Valid   = 1'b1;
                Data_Slot    = 1'b1;
                Tx_Bit       = word_q[bit_idx];
                Del_Reg_Addr = ADDR_W'(chip_cnt);
            end
            TX_DONE: begin
                Word_Done = 1'b1;
            end
            default: ;
        endcase
    end

    assign Aborted = aborted_q;

endmodule

// File: tb/tb_dcsk_tx_sequencer.sv
// Bench for dcsk_tx_sequencer: a queue of expected chips per accepted word, compared every cycle.
module tb_dcsk_tx_sequencer;

    localparam int WORD_W = 32;
    localparam int SF_MAX = 16;
    localparam int ADDR_W = $clog2(SF_MAX);
    localparam int VEC_W  = 9 + ADDR_W;

    localparam logic [1:0] K_REF  = 2'd0;
    localparam logic [1:0] K_DATA = 2'd1;
    localparam logic [1:0] K_DONE = 2'd2;

    logic              Clk = 1'b0;
    logic              Rst;
    logic              Tx_Enable;
    logic              In_Valid;
    logic              In_Ready;
    logic [WORD_W-1:0] In_Word;
    logic [4:0]        Spread_Factor;
    logic              Chaos_Step;
    logic [ADDR_W-1:0] Del_Reg_Addr;
    logic              Del_Reg_Load;
    logic              Del_Reg_Re;
    logic              Data_Slot;
    logic              Tx_Bit;
    logic              Chip_Valid;
    logic              Word_Done;
    logic              Aborted;

    always #5 Clk = ~Clk;

    dcsk_tx_sequencer #(
        .WORD_W(WORD_W),
        .SF_MAX(SF_MAX)
    ) dut (
        .Clk           (Clk),
        .Rst           (Rst),
        .Tx_Enable     (Tx_Enable),
        .In_Valid      (In_Valid),
        .In_Ready      (In_Ready),
        .In_Word       (In_Word),
        .Spread_Factor (Spread_Factor),
        .Chaos_Step    (Chaos_Step),
        .Del_Reg_Addr  (Del_Reg_Addr),
        .Del_Reg_Load  (Del_Reg_Load),
        .Del_Reg_Re    (Del_Reg_Re),
        .Data_Slot     (Data_Slot),
        .Tx_Bit        (Tx_Bit),
        .Chip_Valid    (Chip_Valid),
        .Word_Done     (Word_Done),
        .Aborted       (Aborted)
    );

    typedef struct packed {
        logic [1:0]        kind;
        logic [ADDR_W-1:0] addr;
        logic              bitv;
        logic [5:0]        bit_no;
    } ent_t;

    ent_t q[$];
    logic ab_m = 1'b0;

    int checks    = 0;
    int failures  = 0;
    int edge_cnt  = 0;
    int acc_edge  = -1;
    int done_edge = -1;
    int chaos_cnt = 0;
    int abort_cnt = 0;
    int done_cnt  = 0;
    int max_addr  = 0;
    int nbits     = 0;
    logic bits_seen [64];

    function automatic int clamp_sf(input int s);
        if (s < 2) return 2;
        if (s > SF_MAX) return SF_MAX;
        return s;
    endfunction

    // Reference model: an accepted word expands into its full chip schedule.
    task automatic model_step();
        bit   chip_head;
        bit   ready;
        ent_t e;
        int   sf;
        if (Rst) begin
            q.delete();
            ab_m = 1'b0;
            return;
        end
        chip_head = (q.size() > 0) && (q[0].kind != K_DONE);
        ready     = Tx_Enable && !chip_head;
        if (chip_head && !Tx_Enable) begin
            q.delete();
            ab_m = 1'b1;
        end else begin
            ab_m = 1'b0;
            if (q.size() > 0) void'(q.pop_front());
            if (ready && In_Valid) begin
                sf = clamp_sf(int'(Spread_Factor));
                acc_edge = edge_cnt;
                for (int b = 0; b < WORD_W; b++) begin
                    for (int c = 0; c < sf; c++) begin
                        e.kind = K_REF; e.addr = ADDR_W'(c); e.bitv = 1'b0; e.bit_no = 6'(b);
                        q.push_back(e);
                    end
                    for (int c = 0; c < sf; c++) begin
                        e.kind = K_DATA; e.addr = ADDR_W'(c); e.bitv = In_Word[b]; e.bit_no = 6'(b);
                        q.push_back(e);
                    end
                end
                e.kind = K_DONE; e.addr = '0; e.bitv = 1'b0; e.bit_no = '0;
                q.push_back(e);
            end
        end
    endtask

    function automatic logic [VEC_W-1:0] expected();
        logic ir, cs, ld, re, ds, tb, cv, wd, ab;
        logic [ADDR_W-1:0] ad;
        {ir, cs, ld, re, ds, tb, cv, wd, ab} = '0;
        ad = '0;
        if (!Rst) begin
            ab = ab_m;
            if (q.size() == 0) begin
                ir = Tx_Enable;
            end else if (q[0].kind == K_REF) begin
                cs = 1'b1; ld = 1'b1; cv = 1'b1; ad = q[0].addr;
            end else if (q[0].kind == K_DATA) begin
                re = 1'b1; cv = 1'b1; ds = 1'b1; tb = q[0].bitv; ad = q[0].addr;
            end else begin
                wd = 1'b1; ir = Tx_Enable;
            end
        end
        return {ir, cs, ld, re, ds, tb, cv, wd, ab, ad};
    endfunction

    function automatic logic [VEC_W-1:0] act_vec();
        return {In_Ready, Chaos_Step, Del_Reg_Load, Del_Reg_Re, Data_Slot, Tx_Bit,
                Chip_Valid, Word_Done, Aborted, Del_Reg_Addr};
    endfunction

    task automatic compare();
        logic [VEC_W-1:0] a;
        logic [VEC_W-1:0] e;
        a = act_vec();
        e = expected();
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL cycle_outputs edge=%0d actual=%b required=%b (Rdy,Step,Load,Re,Slot,Bit,CV,Done,Abort,Addr)",
                     edge_cnt, a, e);
        end
        if (Chaos_Step) chaos_cnt++;
        if (Word_Done) begin
            done_cnt++;
            done_edge = edge_cnt;
        end
        if (Aborted) abort_cnt++;
        if (Chip_Valid && int'(Del_Reg_Addr) > max_addr) max_addr = int'(Del_Reg_Addr);
        if (Data_Slot && Chip_Valid && Del_Reg_Addr == '0 && nbits < 64) begin
            bits_seen[nbits] = Tx_Bit;
            nbits++;
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        edge_cnt++;
        model_step();
        @(negedge Clk);
        compare();
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic wait_done(input int budget, input string name);
        int n;
        n = 0;
        while (!Word_Done) begin
            if (n >= budget) begin
                checks++;
                failures++;
                $display("FAIL %s actual=timeout required=Word_Done within %0d cycles", name, budget);
                return;
            end
            tick();
            n++;
        end
    endtask

    task automatic wait_head(input logic [1:0] kind, input int bitn, input int addr,
                             input int budget, input string name);
        int n;
        n = 0;
        while (!((q.size() > 0) && (q[0].kind == kind) &&
                 (bitn < 0 || int'(q[0].bit_no) == bitn) &&
                 (addr < 0 || int'(q[0].addr) == addr))) begin
            if (n >= budget) begin
                checks++;
                failures++;
                $display("FAIL %s actual=timeout required=position within %0d cycles", name, budget);
                return;
            end
            tick();
            n++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        Rst = 1'b1; Tx_Enable = 1'b0; In_Valid = 1'b0; In_Word = '0; Spread_Factor = '0;
        tick();
        tick();
        Rst = 1'b0; Tx_Enable = 1'b1;
        #1;
        check("reset_release_ready", int'(In_Ready), 1);

        // SF=4, word 5: bits 1,0,1,0,0 on the data slots, 128 reference chips.
        Spread_Factor = 5'd4; In_Word = 32'h0000_0005; In_Valid = 1'b1;
        chaos_cnt = 0; nbits = 0;
        tick();
        In_Valid = 1'b0;
        wait_done(400, "w5_done");
        check("w5_chaos_steps", chaos_cnt, 128);
        check("w5_done_latency", done_edge - acc_edge, 256);
        check("w5_bit0", int'(bits_seen[0]), 1);
        check("w5_bit1", int'(bits_seen[1]), 0);
        check("w5_bit2", int'(bits_seen[2]), 1);
        check("w5_bit3", int'(bits_seen[3]), 0);
        check("w5_bit4", int'(bits_seen[4]), 0);
        tick();

        // Clamping at both ends of the spread factor range.
        Spread_Factor = 5'd0; In_Word = $urandom; In_Valid = 1'b1;
        chaos_cnt = 0; max_addr = 0;
        tick();
        In_Valid = 1'b0;
        wait_done(200, "sf0_done");
        check("sf0_max_addr", max_addr, 1);
        check("sf0_chaos_steps", chaos_cnt, 64);
        tick();

        Spread_Factor = 5'd31; In_Word = $urandom; In_Valid = 1'b1;
        chaos_cnt = 0; max_addr = 0;
        tick();
        In_Valid = 1'b0;
        wait_done(1200, "sf31_done");
        check("sf31_max_addr", max_addr, 15);
        check("sf31_chaos_steps", chaos_cnt, 512);
        tick();

        // Two queued words; SF and word change while busy must not affect the first.
        Spread_Factor = 5'd4; In_Word = 32'hA5A5_0F0F; In_Valid = 1'b1;
        chaos_cnt = 0;
        tick();
        Spread_Factor = 5'd8; In_Word = 32'h1234_5678;
        wait_done(400, "queue_first_done");
        check("queue_first_chaos", chaos_cnt, 128);
        chaos_cnt = 0;
        tick();
        check("queue_no_gap_step", int'(Chaos_Step), 1);
        check("queue_no_gap_addr", int'(Del_Reg_Addr), 0);
        In_Valid = 1'b0;
        wait_done(700, "queue_second_done");
        check("queue_second_chaos", chaos_cnt, 256);
        tick();

        // Abort at bit 5, data chip 2.
        Spread_Factor = 5'd4; In_Word = $urandom; In_Valid = 1'b1;
        tick();
        In_Valid = 1'b0;
        wait_head(K_DATA, 5, 2, 400, "abort_reach");
        abort_cnt = 0; done_cnt = 0;
        Tx_Enable = 1'b0;
        tick();
        check("abort_pulse", int'(Aborted), 1);
        check("abort_ready_low", int'(In_Ready), 0);
        Tx_Enable = 1'b1;
        repeat (5) tick();
        check("abort_single_pulse", abort_cnt, 1);
        check("abort_no_done", done_cnt, 0);
        In_Word = 32'h0000_0001; In_Valid = 1'b1;
        tick();
        In_Valid = 1'b0;
        check("after_abort_step", int'(Chaos_Step), 1);
        check("after_abort_addr", int'(Del_Reg_Addr), 0);
        wait_done(400, "after_abort_done");
        tick();

        // Tx_Enable dropped in DONE: pulse still seen, nothing accepted.
        Spread_Factor = 5'd2; In_Word = $urandom; In_Valid = 1'b1;
        tick();
        wait_head(K_DONE, -1, -1, 300, "done_reach");
        Tx_Enable = 1'b0;
        #1;
        check("done_en0_ready", int'(In_Ready), 0);
        check("done_en0_pulse", int'(Word_Done), 1);
        tick();
        check("done_en0_no_accept", int'(Chip_Valid), 0);
        tick();
        In_Valid = 1'b0; Tx_Enable = 1'b1;
        tick();

        // Asynchronous reset during the data slot of bit 7.
        Spread_Factor = 5'd2; In_Word = $urandom; In_Valid = 1'b1;
        tick();
        In_Valid = 1'b0;
        wait_head(K_DATA, 7, -1, 200, "rst_reach");
        Rst = 1'b1;
        #1;
        check("rst_outputs_zero", int'(act_vec()), 0);
        tick();
        tick();
        Rst = 1'b0;
        #1;
        check("rst_release_ready_en", int'(In_Ready), 1);
        tick();
        check("rst_idle_no_chip", int'(Chip_Valid), 0);

        // Randomized traffic with occasional enable drops.
        for (int i = 0; i < 6000; i++) begin
            In_Valid      = ($urandom_range(0, 2) != 0);
            In_Word       = $urandom;
            Spread_Factor = 5'($urandom_range(0, 31));
            Tx_Enable     = ($urandom_range(0, 599) != 0);
            tick();
        end
        In_Valid = 1'b0; Tx_Enable = 1'b1;
        repeat (2) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
